// File: rtl/ast_width_reducer_pkg.sv
// ast_width_reducer_pkg
// Shared definitions for the Avalon-ST width reducer. It holds the default
// widths, helpers that derive counts and widths, the FSM state encoding, and
// the beat-count / empty-out arithmetic for the last word of a packet.
package ast_width_reducer_pkg;

    localparam int unsigned DATA_IN_W_DEF  = 64;
    localparam int unsigned DATA_OUT_W_DEF = 16;
    localparam int unsigned CHANNEL_W_DEF  = 10;

    // Derived counts for the default configuration.
    localparam int unsigned BI_DEF = DATA_IN_W_DEF / 8;
    localparam int unsigned BO_DEF = DATA_OUT_W_DEF / 8;
    localparam int unsigned N_DEF  = DATA_IN_W_DEF / DATA_OUT_W_DEF;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // Width of a field that addresses x things, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    typedef struct packed {
        int unsigned last_idx;
        int unsigned empty_out;
    } beats_t;

    // Beats needed for an eop word and the empty count of its final beat.
    // An illegal empty (>= bytes per word) is treated as one valid byte.
    function automatic beats_t calc_beats(input int unsigned empty_in,
                                          input int unsigned bi,
                                          input int unsigned bo);
        int unsigned v;
        int unsigned beats;
        beats_t      r;
        v           = (empty_in >= bi) ? 1 : bi - empty_in;
        beats       = (v + bo - 1) / bo;
        r.last_idx  = beats - 1;
        r.empty_out = beats * bo - v;
        return r;
    endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// ast_width_reducer
// Avalon-ST width down-converter. It takes one DATA_IN_W word and sends it
// as up to DATA_IN_W/DATA_OUT_W narrow beats, LSB first. Framing (sop/eop),
// channel and byte-accurate empty are kept. Only the beats that carry valid
// bytes of an eop word are sent.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   ast_*_i (wide side)     data/sop/eop/valid/empty/channel in, ready out
//   ast_*_o (narrow side)   data/sop/eop/valid/empty/channel out, ready in
module ast_width_reducer
    import ast_width_reducer_pkg::*;
#(
    parameter int unsigned DATA_IN_W   = DATA_IN_W_DEF,
    parameter int unsigned DATA_OUT_W  = DATA_OUT_W_DEF,
    parameter int unsigned CHANNEL_W   = CHANNEL_W_DEF,
    parameter int unsigned EMPTY_IN_W  = clog2_min1(DATA_IN_W / 8),
    parameter int unsigned EMPTY_OUT_W = clog2_min1(DATA_OUT_W / 8)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int unsigned N  = DATA_IN_W / DATA_OUT_W;
    localparam int unsigned BI = DATA_IN_W / 8;
    localparam int unsigned BO = DATA_OUT_W / 8;
    localparam int unsigned CW = clog2_min1(N);

    state_t                        state_q;
    logic [N-1:0][DATA_OUT_W-1:0]  held_q;
    logic [CW-1:0]                 beat_q;
    logic [CW-1:0]                 last_idx_q;
    logic [CW-1:0]                 last_idx_d;
    logic                          sop_q;
    logic                          eop_q;
    logic [EMPTY_OUT_W-1:0]        empty_out_q;
    logic [EMPTY_OUT_W-1:0]        empty_out_d;
    logic [CHANNEL_W-1:0]          channel_q;

    beats_t                        eop_calc;
    logic                          in_hs;
    logic                          out_hs;
    logic                          last_beat;

    assign last_beat = (beat_q == last_idx_q);
    assign in_hs     = ast_valid_i & ast_ready_o;
    assign out_hs    = ast_valid_o & ast_ready_i;

    // The word after the final beat can be taken in the same cycle, so ready
    // to the source follows ready from the sink combinationally.
    assign ast_ready_o = (state_q == ST_IDLE) |
                         ((state_q == ST_SEND) & last_beat & ast_ready_i);

    // Beat plan for the incoming word, latched on the input handshake.
    always_comb begin
        eop_calc = calc_beats(32'(ast_empty_i), BI, BO);
        if (ast_endofpacket_i) begin
            last_idx_d  = CW'(eop_calc.last_idx);
            empty_out_d = EMPTY_OUT_W'(eop_calc.empty_out);
        end else begin
            last_idx_d  = CW'(N - 1);
            empty_out_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            beat_q      <= '0;
            last_idx_q  <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            empty_out_q <= '0;
            channel_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_hs) begin
                        state_q     <= ST_SEND;
                        held_q      <= ast_data_i;
                        beat_q      <= '0;
                        last_idx_q  <= last_idx_d;
                        sop_q       <= ast_startofpacket_i;
                        eop_q       <= ast_endofpacket_i;
                        empty_out_q <= empty_out_d;
                        channel_q   <= ast_channel_i;
                    end
                end
                ST_SEND: begin
                    if (out_hs) begin
                        if (!last_beat) begin
                            beat_q <= beat_q + 1'b1;
                        end else if (in_hs) begin
                            held_q      <= ast_data_i;
                            beat_q      <= '0;
                            last_idx_q  <= last_idx_d;
                            sop_q       <= ast_startofpacket_i;
                            eop_q       <= ast_endofpacket_i;
                            empty_out_q <= empty_out_d;
                            channel_q   <= ast_channel_i;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    generate
        if (N == 1) begin : g_pass
            assign ast_data_o = held_q[0];
        end else begin : g_mux
            assign ast_data_o = held_q[beat_q];
        end
    endgenerate

    assign ast_valid_o         = (state_q == ST_SEND);
    assign ast_startofpacket_o = ast_valid_o & sop_q & (beat_q == '0);
    assign ast_endofpacket_o   = ast_valid_o & eop_q & last_beat;
    assign ast_empty_o         = (ast_valid_o & eop_q & last_beat) ? empty_out_q : '0;
    assign ast_channel_o       = channel_q;

    // An eop word must carry at least one valid byte.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (in_hs && ast_endofpacket_i) |-> (32'(ast_empty_i) < BI))
        else $error("ast_width_reducer: illegal empty_i %0d on eop word", ast_empty_i);

endmodule

// File: tb/tb_ast_width_reducer.sv
module tb_ast_width_reducer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 64 -> 16 instance
    logic [63:0] in_data = '0;
    logic        in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
    logic [2:0]  in_empty = '0;
    logic [9:0]  in_chan = '0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_sop, out_eop, out_valid;
    logic [0:0]  out_empty;
    logic [9:0]  out_chan;
    logic        out_ready = 1'b1;

    // 64 -> 64 instance (N=1)
    logic [63:0] in_data1 = '0;
    logic        in_sop1 = 1'b0, in_eop1 = 1'b0, in_valid1 = 1'b0;
    logic [2:0]  in_empty1 = '0;
    logic [9:0]  in_chan1 = '0;
    logic        in_ready1;
    logic [63:0] out_data1;
    logic        out_sop1, out_eop1, out_valid1;
    logic [2:0]  out_empty1;
    logic [9:0]  out_chan1;
    logic        out_ready1 = 1'b1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        e;
        logic [0:0]  em;
        logic [9:0]  ch;
    } beat_t;
    beat_t exp_q[$];
    bit    drv_done;
    bit    mon_done;

    always #5 clk = ~clk;

    ast_width_reducer #(.DATA_IN_W(64), .DATA_OUT_W(16), .CHANNEL_W(10)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ast_data_i(in_data), .ast_startofpacket_i(in_sop), .ast_endofpacket_i(in_eop),
        .ast_valid_i(in_valid), .ast_empty_i(in_empty), .ast_channel_i(in_chan),
        .ast_ready_o(in_ready),
        .ast_data_o(out_data), .ast_startofpacket_o(out_sop), .ast_endofpacket_o(out_eop),
        .ast_valid_o(out_valid), .ast_empty_o(out_empty), .ast_channel_o(out_chan),
        .ast_ready_i(out_ready)
    );

    ast_width_reducer #(.DATA_IN_W(64), .DATA_OUT_W(64), .CHANNEL_W(10)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .ast_data_i(in_data1), .ast_startofpacket_i(in_sop1), .ast_endofpacket_i(in_eop1),
        .ast_valid_i(in_valid1), .ast_empty_i(in_empty1), .ast_channel_i(in_chan1),
        .ast_ready_o(in_ready1),
        .ast_data_o(out_data1), .ast_startofpacket_o(out_sop1), .ast_endofpacket_o(out_eop1),
        .ast_valid_o(out_valid1), .ast_empty_o(out_empty1), .ast_channel_o(out_chan1),
        .ast_ready_i(out_ready1)
    );

    // Presents a word on the wide input and returns just after the edge
    // that accepted it (valid_i left high; the caller decides what follows).
    task automatic drive_word(input logic [63:0] d, input logic s, input logic e,
                              input logic [2:0] em, input logic [9:0] ch, output bit ok);
        int unsigned n;
        n = 0;
        ok = 1'b0;
        in_data = d; in_sop = s; in_eop = e; in_empty = em; in_chan = ch; in_valid = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL drive_timeout: ready_o stayed low for %0d cycles, required a handshake", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", out_data); end
        n_cmp++; if ({out_sop, out_eop, out_empty} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {out_sop, out_eop, out_empty}); end
        n_cmp++; if (out_chan !== 10'h0) begin n_err++; $display("FAIL reset_chan: got %h want 000", out_chan); end
        n_cmp++; if ({out_valid1, in_ready1} !== 2'b01) begin n_err++; $display("FAIL reset_n1: got %b want 01", {out_valid1, in_ready1}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        bit ok;
        logic [15:0] exp_d [4];
        exp_d[0] = 16'h2211; exp_d[1] = 16'h4433; exp_d[2] = 16'h6655; exp_d[3] = 16'h8877;
        out_ready = 1'b1;
        drive_word(64'h8877_6655_4433_2211, 1'b1, 1'b0, 3'd0, 10'h155, ok);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin n_err++; $display("FAIL single_beat%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_d[k]); end
            n_cmp++; if ({out_sop, out_eop, out_empty} !== {(k == 0), 1'b0, 1'b0}) begin n_err++; $display("FAIL single_flags%0d: got sop/eop/empty=%b want %b", k, {out_sop, out_eop, out_empty}, {(k == 0), 2'b00}); end
            n_cmp++; if (out_chan !== 10'h155) begin n_err++; $display("FAIL single_chan%0d: got %h want 155", k, out_chan); end
            @(posedge clk);
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_end: valid got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_eop_empty();
        bit ok;
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h2211; exp_d[1] = 16'h4433; exp_d[2] = 16'h6655;
        out_ready = 1'b1;
        drive_word(64'h8877_6655_4433_2211, 1'b1, 1'b1, 3'd3, 10'h0AA, ok);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin n_err++; $display("FAIL eop_beat%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_d[k]); end
            n_cmp++; if ({out_sop, out_eop, out_empty} !== {(k == 0), (k == 2), (k == 2)}) begin n_err++; $display("FAIL eop_flags%0d: got sop/eop/empty=%b want %b", k, {out_sop, out_eop, out_empty}, {(k == 0), (k == 2), (k == 2)}); end
            if (k == 2) begin
                n_cmp++; if (out_data[7:0] !== 8'h55) begin n_err++; $display("FAIL eop_lastbyte: got %h want 55", out_data[7:0]); end
            end
            @(posedge clk);
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL eop_end: valid got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int unsigned idx;
        int unsigned b;
        bit hs;
        logic [15:0] ed;
        out_ready = 1'b1;
        idx = 0;
        in_data = 64'h0003_0002_0001_0000; in_sop = 1'b1; in_eop = 1'b0; in_empty = '0;
        in_chan = 10'h011; in_valid = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL b2b_start: valid/ready got %b want 01", {out_valid, in_ready}); end
            end else if (cyc <= 12) begin
                b = cyc - 1;
                ed = 16'((b / 4) * 16 + (b % 4));
                n_cmp++; if (out_valid !== 1'b1 || out_data !== ed) begin n_err++; $display("FAIL b2b_beat%0d: got v=%b d=%h want v=1 d=%h", b, out_valid, out_data, ed); end
                n_cmp++; if ({out_sop, out_eop} !== {(b == 0), (b == 11)}) begin n_err++; $display("FAIL b2b_frame%0d: got sop/eop=%b want %b", b, {out_sop, out_eop}, {(b == 0), (b == 11)}); end
                n_cmp++; if (in_ready !== ((b % 4) == 3)) begin n_err++; $display("FAIL b2b_ready%0d: got %b want %b", b, in_ready, ((b % 4) == 3)); end
            end else begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: valid got %b want 0", out_valid); end
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                if (idx < 3) begin
                    in_data = {16'(idx * 16 + 3), 16'(idx * 16 + 2), 16'(idx * 16 + 1), 16'(idx * 16)};
                    in_sop = 1'b0;
                    in_eop = (idx == 2);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        drive_word(64'h0F0E_0D0C_0B0A_0908, 1'b1, 1'b1, 3'd0, 10'h003, ok);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_data !== 16'h0B0A) begin n_err++; $display("FAIL rmid_beat1: got %h want 0b0a", out_data); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL rmid_async: valid/ready got %b want 01", {out_valid, in_ready}); end
        n_cmp++; if ({out_data, out_sop, out_eop} !== 18'h0) begin n_err++; $display("FAIL rmid_clear: data/sop/eop got %h want 0", {out_data, out_sop, out_eop}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_idle%0d: valid got %b want 0", i, out_valid); end
        end
        @(posedge clk); #1;
        drive_word(64'h1716_1514_1312_1110, 1'b1, 1'b1, 3'd4, 10'h3FF, ok);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({out_valid, out_data, out_sop, out_eop} !== {1'b1, 16'h1110, 2'b10}) begin n_err++; $display("FAIL rmid_next0: got v=%b d=%h sop=%b eop=%b want v=1 d=1110 sop=1 eop=0", out_valid, out_data, out_sop, out_eop); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({out_valid, out_data, out_sop, out_eop, out_empty} !== {1'b1, 16'h1312, 3'b010}) begin n_err++; $display("FAIL rmid_next1: got v=%b d=%h sop=%b eop=%b em=%b want v=1 d=1312 sop=0 eop=1 em=0", out_valid, out_data, out_sop, out_eop, out_empty); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_end: valid got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_n1();
        @(negedge clk);
        n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL n1_ready: got %b want 1", in_ready1); end
        @(posedge clk); #1;
        in_data1 = 64'h1122_3344_5566_7788; in_sop1 = 1'b1; in_eop1 = 1'b1;
        in_empty1 = 3'd5; in_chan1 = 10'h02A; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        n_cmp++; if ({out_valid1, out_data1} !== {1'b1, 64'h1122_3344_5566_7788}) begin n_err++; $display("FAIL n1_data: got v=%b d=%h want v=1 d=1122334455667788", out_valid1, out_data1); end
        n_cmp++; if ({out_sop1, out_eop1, out_empty1, out_chan1} !== {2'b11, 3'd5, 10'h02A}) begin n_err++; $display("FAIL n1_side: got sop=%b eop=%b em=%0d ch=%h want 1 1 5 02a", out_sop1, out_eop1, out_empty1, out_chan1); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL n1_end: valid got %b want 0", out_valid1); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        drv_done = 1'b0;
        mon_done = 1'b0;
        exp_q.delete();
        fork
            begin : driver
                bit ok;
                int unsigned nw, nvb, nb;
                logic [63:0] d;
                logic [2:0]  em;
                logic [9:0]  ch;
                logic        eop;
                for (int p = 0; p < 100; p++) begin
                    nw = $urandom_range(1, 3);
                    ch = 10'($urandom);
                    for (int w = 0; w < int'(nw); w++) begin
                        d   = {$urandom, $urandom};
                        eop = (w == int'(nw) - 1);
                        em  = 3'($urandom);
                        drive_word(d, (w == 0), eop, em, ch, ok);
                        if (ok) begin
                            nvb = eop ? 8 - int'(em) : 8;
                            nb  = (nvb + 1) / 2;
                            for (int k = 0; k < int'(nb); k++) begin
                                exp_q.push_back({d[16*k +: 16], (w == 0) && (k == 0),
                                                 eop && (k == int'(nb) - 1),
                                                 (eop && (k == int'(nb) - 1)) ? 1'(nb * 2 - nvb) : 1'b0,
                                                 ch});
                            end
                        end
                        if ($urandom_range(0, 3) == 0) begin
                            in_valid = 1'b0;
                            @(posedge clk); #1;
                        end
                    end
                end
                in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin : sink
                while (!mon_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            begin : monitor
                int unsigned cyc;
                bit          prev_stall;
                beat_t       prev, got, e;
                cyc = 0;
                prev_stall = 1'b0;
                prev = '0;
                while (!(drv_done && exp_q.size() == 0) && cyc < 30000) begin
                    @(negedge clk);
                    cyc++;
                    got = {out_data, out_sop, out_eop, out_empty, out_chan};
                    if (prev_stall) begin
                        n_cmp++;
                        if (out_valid !== 1'b1 || got !== prev) begin
                            n_err++;
                            $display("FAIL rnd_stall: got v=%b beat=%h want v=1 beat=%h", out_valid, got, prev);
                        end
                    end
                    if (out_valid && out_ready) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL rnd_extra: got beat=%h want no beat", got);
                        end else begin
                            e = exp_q.pop_front();
                            if (got !== e) begin
                                n_err++;
                                $display("FAIL rnd_beat: got d=%h s=%b e=%b em=%b ch=%h want d=%h s=%b e=%b em=%b ch=%h",
                                         got.d, got.s, got.e, got.em, got.ch, e.d, e.s, e.e, e.em, e.ch);
                            end
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    prev = got;
                end
                if (!drv_done || exp_q.size() != 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rnd_timeout: got %0d beats outstanding want 0", exp_q.size());
                end
                mon_done = 1'b1;
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_eop_empty();
        test_back_to_back();
        test_reset_mid();
        test_n1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
